// File: rtl/hbmc_pkg.sv
// Shared HyperBus controller types and constants.
package hbmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CA   = 3'd1,
    ST_LAT  = 3'd2,
    ST_DATA = 3'd3,
    ST_REL  = 3'd4
  } hbmc_state_e;

  localparam int CA_RW    = 47;   // 1 = read
  localparam int CA_AS    = 46;   // 1 = register space
  localparam int CA_BEATS = 3;

  localparam logic [1:0] CA_LAST_BEAT  = 2'(CA_BEATS - 1);
  localparam logic [1:0] RWDS_MASK_ALL = 2'b11;

  // Select one 16-bit command/address beat, most significant beat first.
  function automatic logic [15:0] ca_beat(input logic [47:0] ca, input logic [1:0] idx);
    logic [15:0] beat;
    case (idx)
      2'd0:    beat = ca[47:32];
      2'd1:    beat = ca[31:16];
      default: beat = ca[15:0];
    endcase
    return beat;
  endfunction

endpackage

// File: rtl/hbmc_ddr_pack.sv
// Packs a 16-bit DDR word into per-pin {fall, rise} bit pairs.
// The upper byte goes out on the rising edge, the lower byte on the falling edge.
module hbmc_ddr_pack (
  input  logic [15:0] word_i,
  output logic [15:0] pins_o
);

  // Interleave: pins_o[2k] = rise bit of DQ[k], pins_o[2k+1] = fall bit of DQ[k].
  always_comb begin
    pins_o = '0;
    for (int k = 0; k < 8; k++) begin
      pins_o[2*k]   = word_i[8+k];
      pins_o[2*k+1] = word_i[k];
    end
  end

endmodule

// File: rtl/hbmc_dq_tx.sv
// HyperBus DQ/RWDS transmit sequencer (ODDR clock domain).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | bus released; start latches the transaction and emits CA beat 0
// CA      | emits CA beats 1..2, then picks read / register write / memory write
// LAT     | bus tristated for lat_cycles clocks before memory-write data
// DATA    | one write word (or filler beat) per clock until the count is spent
// REL     | release bus, pulse done
//
// Output registers are loaded with the action of the current state, so every
// beat is visible on the clock after the state that produced it. A word
// accepted in DATA therefore appears on the pins one clock later, and the
// released bus / done pulse is visible in the clock after REL.
module hbmc_dq_tx
  import hbmc_pkg::*;
#(
  parameter int LAT_WIDTH = 5,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [47:0]          ca_i,
  input  logic [LAT_WIDTH-1:0] lat_cycles_i,
  input  logic [LEN_WIDTH-1:0] word_count_i,
  input  logic [15:0]          wdata_i,
  input  logic [1:0]           wmask_i,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  output logic [15:0]          dq_sdr_o,
  output logic                 dq_t_o,
  output logic [1:0]           rwds_sdr_o,
  output logic                 rwds_t_o,
  output logic                 busy_o,
  output logic                 done_o
);

  hbmc_state_e          state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  logic [LAT_WIDTH-1:0] lat_q, lat_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [LEN_WIDTH-1:0] wc_q, wc_d;
  logic [47:0]          ca_q, ca_d;

  logic [15:0]          word_d;
  logic [15:0]          dq_sdr_q, dq_sdr_d;
  logic                 dq_t_q, dq_t_d;
  logic [1:0]           rwds_sdr_q, rwds_sdr_d;
  logic                 rwds_t_q, rwds_t_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 is_read;
  logic                 is_reg_wr;
  logic                 accept;
  logic [LAT_WIDTH-1:0] lat_dec;
  logic [LEN_WIDTH-1:0] rem_dec;

  assign is_read   = ca_q[CA_RW];
  assign is_reg_wr = !ca_q[CA_RW] && ca_q[CA_AS];
  assign wready_o  = (state_q == ST_DATA) && (rem_q != '0);
  assign accept    = wvalid_i && wready_o;
  assign lat_dec   = lat_q - 1'b1;
  assign rem_dec   = rem_q - 1'b1;

  hbmc_ddr_pack u_pack (
    .word_i (word_d),
    .pins_o (dq_sdr_d)
  );

  // Next-state, counter and next-output logic.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    rem_d      = rem_q;
    wc_d       = wc_q;
    ca_d       = ca_q;
    word_d     = '0;
    dq_t_d     = 1'b1;
    rwds_sdr_d = '0;
    rwds_t_d   = 1'b1;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ca_d    = ca_i;
          lat_d   = lat_cycles_i;
          wc_d    = word_count_i;
          word_d  = ca_beat(ca_i, 2'd0);
          dq_t_d  = 1'b0;
          beat_d  = 2'd1;
          state_d = ST_CA;
        end
      end

      ST_CA: begin
        word_d = ca_beat(ca_q, beat_q);
        dq_t_d = 1'b0;
        if (beat_q == CA_LAST_BEAT) begin
          beat_d = '0;
          if (is_read) begin
            state_d = ST_REL;
          end else if (is_reg_wr) begin
            rem_d   = LEN_WIDTH'(1);
            state_d = ST_DATA;
          end else begin
            rem_d   = (wc_q == '0) ? LEN_WIDTH'(1) : wc_q;
            state_d = (lat_q == '0) ? ST_DATA : ST_LAT;
          end
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end

      ST_LAT: begin
        lat_d = lat_dec;
        if (lat_dec == '0) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        dq_t_d   = 1'b0;
        rwds_t_d = is_reg_wr;
        if (accept) begin
          word_d     = wdata_i;
          rwds_sdr_d = is_reg_wr ? 2'b00 : wmask_i;
          rem_d      = rem_dec;
          if (rem_dec == '0) begin
            state_d = ST_REL;
          end
        end else begin
          // Underflow: keep the bus driven with a fully masked filler beat.
          word_d     = '0;
          rwds_sdr_d = is_reg_wr ? 2'b00 : RWDS_MASK_ALL;
        end
      end

      ST_REL: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered pin outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      lat_q      <= '0;
      rem_q      <= '0;
      wc_q       <= '0;
      ca_q       <= '0;
      dq_sdr_q   <= '0;
      dq_t_q     <= 1'b1;
      rwds_sdr_q <= '0;
      rwds_t_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      rem_q      <= rem_d;
      wc_q       <= wc_d;
      ca_q       <= ca_d;
      dq_sdr_q   <= dq_sdr_d;
      dq_t_q     <= dq_t_d;
      rwds_sdr_q <= rwds_sdr_d;
      rwds_t_q   <= rwds_t_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign dq_sdr_o   = dq_sdr_q;
  assign dq_t_o     = dq_t_q;
  assign rwds_sdr_o = rwds_sdr_q;
  assign rwds_t_o   = rwds_t_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_hbmc_dq_tx.sv
// Scoreboard bench for hbmc_dq_tx: expected pin beats are queued as stimulus
// is driven and popped by a monitor whenever the DUT drives DQ or pulses done.
module tb_hbmc_dq_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [47:0] ca = '0;
  logic [4:0]  lat_cycles = '0;
  logic [15:0] word_count = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  wmask = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [15:0] dq_sdr;
  logic        dq_t;
  logic [1:0]  rwds_sdr;
  logic        rwds_t;
  logic        busy;
  logic        done;

  hbmc_dq_tx #(.LAT_WIDTH(5), .LEN_WIDTH(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .ca_i         (ca),
    .lat_cycles_i (lat_cycles),
    .word_count_i (word_count),
    .wdata_i      (wdata),
    .wmask_i      (wmask),
    .wvalid_i     (wvalid),
    .wready_o     (wready),
    .dq_sdr_o     (dq_sdr),
    .dq_t_o       (dq_t),
    .rwds_sdr_o   (rwds_sdr),
    .rwds_t_o     (rwds_t),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [15:0] dq;
    logic        rwds_t;
    logic [1:0]  rwds;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] wd[$];
  logic [1:0]  wm[$];

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  int run = 0;
  int max_gap = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic [15:0] w);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = (i % 2 == 0) ? w[8 + i/2] : w[i/2];
    return p;
  endfunction

  task automatic push_beat(input logic [15:0] w, input logic rt, input logic [1:0] rw);
    exp_t e;
    e.is_done = 1'b0; e.dq = pk(w); e.rwds_t = rt; e.rwds = rw;
    sbq.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.dq = '0; e.rwds_t = 1'b1; e.rwds = '0;
    sbq.push_back(e);
  endtask

  // Monitor: every driven beat or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (!dq_t) begin
        if (run > max_gap) max_gap = run;
        run = 0;
      end else if (!done) begin
        run++;
      end
      if (!dq_t || done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", {done, ~dq_t, dq_sdr}, 18'h0);
        end else begin
          e = sbq.pop_front();
          if (e.is_done) begin
            chk("done_pulse", {done, dq_t, rwds_t, dq_sdr}, {1'b1, 1'b1, 1'b1, 16'h0});
          end else begin
            chk("beat", {done, rwds_t, dq_sdr}, {1'b0, e.rwds_t, e.dq});
            if (!e.rwds_t) chk("rwds_sdr", rwds_sdr, e.rwds);
          end
        end
      end
    end
  end

  // Issue a transaction once the sequencer is free; queue its CA beats.
  task automatic start_txn(input logic [47:0] c, input int lat, input int wc);
    int b = 0;
    while (busy && b < 100) begin @(posedge clk); #1; b++; end
    chk("start_wait_idle", busy, 0);
    start = 1'b1; ca = c; lat_cycles = 5'(lat); word_count = 16'(wc);
    push_beat(c[47:32], 1'b1, 2'b00);
    push_beat(c[31:16], 1'b1, 2'b00);
    push_beat(c[15:0],  1'b1, 2'b00);
    if (c[47]) push_done();
    @(posedge clk); #1;
    start = 1'b0;
    run = 0; max_gap = 0;
  endtask

  // Feed write words from wd/wm, withholding wvalid for stall_n cycles after
  // stall_after words, until the transaction ends.
  task automatic feed(input bit reg_wr, input int n_exp, input int stall_after,
                      input int stall_n, output int acc, output int dcyc);
    int sent = 0, stalled = 0, budget = 0;
    acc = 0; dcyc = 0;
    while (busy && budget < 200) begin
      wvalid = 1'b0;
      if (wready) begin
        dcyc++;
        if (sent == stall_after && stalled < stall_n) begin
          stalled++;
          push_beat(16'h0, reg_wr, reg_wr ? 2'b00 : 2'b11);
        end else if (wd.size() > 0) begin
          wvalid = 1'b1;
          wdata = wd.pop_front();
          wmask = wm.pop_front();
          push_beat(wdata, reg_wr, reg_wr ? 2'b00 : wmask);
          sent++; acc++;
          if (acc == n_exp) push_done();
        end else begin
          push_beat(16'h0, reg_wr, reg_wr ? 2'b00 : 2'b11);
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    wvalid = 1'b0;
    chk("feed_finish", busy, 0);
  endtask

  task automatic wait_idle(input string tag, output int cyc, output bit saw_wr);
    cyc = 1; saw_wr = 1'b0;
    while (busy && cyc < 100) begin
      if (wready) saw_wr = 1'b1;
      @(posedge clk); #1; cyc++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    int acc, dcyc, cyc;
    bit saw_wr;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dq_t", dq_t, 1);
    chk("rst_rwds_t", rwds_t, 1);
    chk("rst_dq_sdr", dq_sdr, 0);
    chk("rst_rwds_sdr", rwds_sdr, 0);
    chk("rst_busy_done_wready", {busy, done, wready}, 3'b000);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // 1. Read: three CA beats, done on the 4th cycle after start
    start_txn(48'hA000_0012_0034, 3, 4);
    chk("rd_busy", busy, 1);
    wait_idle("rd_finish", cyc, saw_wr);
    chk("rd_done_cycle", cyc, 4);
    chk("rd_done_now", done, 1);
    chk("rd_no_wready", saw_wr, 0);
    @(posedge clk); #1;
    chk("rd_released", {dq_t, rwds_t, done}, 3'b110);

    // 2. Memory write, 6 latency clocks, 2 words
    wd = '{16'h1122, 16'h3344}; wm = '{2'b00, 2'b10};
    start_txn(48'h0000_1234_5678, 6, 2);
    feed(1'b0, 2, -1, 0, acc, dcyc);
    chk("mw_words", acc, 2);
    chk("mw_data_cycles", dcyc, 2);
    chk("mw_lat_gap", max_gap, 6);

    // 3. Register write: one word right after CA, latency/count ignored
    wd = '{16'h8F1F, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    wm = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    start_txn(48'h4000_0000_0001, 7, 5);
    feed(1'b1, 1, -1, 0, acc, dcyc);
    chk("rw_words", acc, 1);
    chk("rw_data_cycles", dcyc, 1);
    chk("rw_no_gap", max_gap, 0);
    wd.delete(); wm.delete();

    // 4. Underflow: 3 words with 2 stall cycles after the first
    wd = '{16'hA1B2, 16'hC3D4, 16'hE5F6}; wm = '{2'b01, 2'b00, 2'b11};
    start_txn(48'h0012_3400_0008, 2, 3);
    feed(1'b0, 3, 1, 2, acc, dcyc);
    chk("uf_words", acc, 3);
    chk("uf_data_cycles", dcyc, 5);

    // 5. Reset during the second data word
    start_txn(48'h2000_0000_0040, 0, 3);
    cyc = 0;
    while (!wready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("rstm_wready", wready, 1);
    wvalid = 1'b1; wdata = 16'h5A5A; wmask = 2'b00;
    push_beat(16'h5A5A, 1'b0, 2'b00);
    @(posedge clk); #1;
    wdata = 16'hC3C3; rst = 1'b1;
    @(posedge clk); #1;
    chk("rstm_outputs", {dq_t, rwds_t, busy, done, wready}, 5'b11000);
    chk("rstm_dq_sdr", dq_sdr, 0);
    rst = 1'b0; wvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstm_sb_empty", sbq.size(), 0);
    start_txn(48'h8000_0000_00AA, 0, 0);
    wait_idle("rstm_read_finish", cyc, saw_wr);
    chk("rstm_read_done", done, 1);

    // 6. start while busy is ignored; word_count=0 sends exactly one word
    @(posedge clk); #1;
    start_txn(48'hC000_0000_0077, 0, 0);
    start = 1'b1; ca = 48'h4111_2222_3333; lat_cycles = 5'd3; word_count = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("busy_start_finish", cyc, saw_wr);
    @(posedge clk); #1;
    chk("busy_start_no_restart", busy, 0);
    wd = '{16'h7E81, 16'hBAD0}; wm = '{2'b10, 2'b00};
    start_txn(48'h0000_0000_0100, 0, 0);
    feed(1'b0, 1, -1, 0, acc, dcyc);
    chk("wc0_words", acc, 1);
    chk("wc0_data_cycles", dcyc, 1);
    wd.delete(); wm.delete();

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
